// File: rtl/fcpu_pkg.sv
// Shared types and widths for the fcpu core.
package fcpu_pkg;

    localparam int N_ROB_W     = 4;
    localparam int N_ROB       = 2 ** N_ROB_W;
    localparam int DATA_W      = 32;
    localparam int CRAM_ADDR_W = 14;
    localparam int REG_ADDR_W  = 5;
    localparam int INSTR_W     = 8;
    localparam int RSV_ID_W    = 5;
    localparam int CDB_W       = RSV_ID_W + DATA_W;

    typedef enum logic [2:0] {
        COMMIT_NONE   = 3'd0,
        COMMIT_ALU    = 3'd1,
        COMMIT_LOAD   = 3'd2,
        COMMIT_STORE  = 3'd3,
        COMMIT_BRANCH = 3'd4,
        COMMIT_JUMP   = 3'd5
    } commit_type_t;

    // Pointer carries one extra wrap bit so full and empty are distinguishable.
    typedef logic [N_ROB_W:0] rob_ptr_t;

    typedef struct packed {
        logic                   valid;
        logic                   ready;
        logic                   mispredict;
        commit_type_t           ctype;
        logic [REG_ADDR_W-1:0]  dst_reg;
        logic [INSTR_W-1:0]     opcode;
        logic [DATA_W-1:0]      value;
        logic [CRAM_ADDR_W-1:0] target;
    } rob_entry_t;

    // Slot index addressed by a pointer (drops the wrap bit).
    function automatic logic [N_ROB_W-1:0] rob_idx(input rob_ptr_t p);
        return p[N_ROB_W-1:0];
    endfunction

endpackage

// File: rtl/fcpu_rob.sv
// fcpu reorder buffer: in-order retirement of out-of-order results, with
// squash and PC redirect when a mispredicted branch reaches the head.
module fcpu_rob
    import fcpu_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   disp_valid,
    output logic                   disp_ready,
    input  logic [2:0]             disp_type,
    input  logic [REG_ADDR_W-1:0]  disp_dst_reg,
    input  logic [INSTR_W-1:0]     disp_opcode,
    output logic [N_ROB_W-1:0]     disp_tag,
    input  logic                   cdb_valid,
    input  logic [CDB_W-1:0]       cdb_data,
    input  logic                   br_valid,
    input  logic [N_ROB_W-1:0]     br_tag,
    input  logic                   br_mispredict,
    input  logic [CRAM_ADDR_W-1:0] br_target,
    output logic                   commit_valid,
    input  logic                   commit_ready,
    output logic [2:0]             commit_type,
    output logic [REG_ADDR_W-1:0]  commit_dst_reg,
    output logic [INSTR_W-1:0]     commit_opcode,
    output logic [DATA_W-1:0]      commit_value,
    output logic                   flush,
    output logic [CRAM_ADDR_W-1:0] redirect_pc,
    output logic [N_ROB_W:0]       count
);

    rob_entry_t rob_q [N_ROB];
    rob_entry_t rob_d [N_ROB];
    rob_ptr_t   head_q, head_d;
    rob_ptr_t   tail_q, tail_d;

    rob_entry_t              head_ent;
    logic                    full;
    logic                    commit_fire;
    logic                    disp_fire;
    logic [RSV_ID_W-1:0]     cdb_tag;
    logic [DATA_W-1:0]       cdb_val;
    logic                    cdb_hit;

    assign head_ent = rob_q[rob_idx(head_q)];
    assign cdb_tag  = cdb_data[CDB_W-1:DATA_W];
    assign cdb_val  = cdb_data[DATA_W-1:0];
    // Tags with upper bits set belong to producers outside the ROB.
    assign cdb_hit  = cdb_valid && (cdb_tag[RSV_ID_W-1:N_ROB_W] == '0)
                      && rob_q[cdb_tag[N_ROB_W-1:0]].valid;

    // Handshake and status outputs, all derived from registered state.
    always_comb begin
        full           = (rob_idx(head_q) == rob_idx(tail_q)) && (head_q[N_ROB_W] != tail_q[N_ROB_W]);
        // Held low while reset is asserted so no retirement leaks out of a reset cycle.
        commit_valid   = rst_n && head_ent.valid && head_ent.ready;
        commit_fire    = commit_valid && commit_ready;
        flush          = commit_fire && (head_ent.ctype == COMMIT_BRANCH) && head_ent.mispredict;
        disp_ready     = !full && !flush;
        disp_fire      = disp_valid && disp_ready;
        disp_tag       = rob_idx(tail_q);
        commit_type    = head_ent.ctype;
        commit_dst_reg = head_ent.dst_reg;
        commit_opcode  = head_ent.opcode;
        commit_value   = head_ent.value;
        redirect_pc    = head_ent.target;
        count          = tail_q - head_q;
    end

    // Next-state for entries and pointers; later writes in this block take priority.
    always_comb begin
        rob_d  = rob_q;
        head_d = head_q;
        tail_d = tail_q;

        if (cdb_hit) begin
            rob_d[cdb_tag[N_ROB_W-1:0]].value = cdb_val;
            rob_d[cdb_tag[N_ROB_W-1:0]].ready = 1'b1;
        end

        if (br_valid && rob_q[br_tag].valid) begin
            rob_d[br_tag].ready      = 1'b1;
            rob_d[br_tag].mispredict = br_mispredict;
            rob_d[br_tag].target     = br_target;
        end

        if (commit_fire) begin
            rob_d[rob_idx(head_q)].valid = 1'b0;
            head_d = head_q + rob_ptr_t'(1);
        end

        if (disp_fire) begin
            rob_d[rob_idx(tail_q)] = '{
                valid:      1'b1,
                ready:      1'b0,
                mispredict: 1'b0,
                ctype:      commit_type_t'(disp_type),
                dst_reg:    disp_dst_reg,
                opcode:     disp_opcode,
                value:      '0,
                target:     '0
            };
            tail_d = tail_q + rob_ptr_t'(1);
        end

        if (flush) begin
            for (int i = 0; i < N_ROB; i++) begin
                rob_d[i].valid = 1'b0;
            end
            tail_d = head_d;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q <= '0;
            tail_q <= '0;
            // NOTE: only the control bits are reset; payload fields are always
            // rewritten at dispatch before they can be observed, so they need no reset.
            for (int i = 0; i < N_ROB; i++) begin
                rob_q[i].valid      <= 1'b0;
                rob_q[i].ready      <= 1'b0;
                rob_q[i].mispredict <= 1'b0;
            end
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            rob_q  <= rob_d;
        end
    end

endmodule
